ro_scan_controller: RTL and testbench
=====================================

Name: ro_scan_controller

Overview:
- Sequences a bank of N_RO ring oscillators. Enables one oscillator at a time and lets it settle. Counts its rising edges over a fixed window of the system clock, then disables it.
- Reports each count through a valid/ready result port.
- Sits between the ring oscillator instances and the characterisation/readout logic. It is the only driver of each oscillator's enable input.

Parameters:
- N_RO, 4, number of ring oscillators scanned (1..16).
- WINDOW_CYC, 1024, measurement window length in clk cycles (>=1).
- SETTLE_CYC, 16, clk cycles between enabling an oscillator and starting the count (>=3, covers synchroniser flush).
- CNT_W, 16, width of the edge counter and result_count.

Ports:
- clk  input  1  system clock; one clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  single-cycle request to begin a scan; acted on only in IDLE.
- abort  input  1  stops the scan immediately; no result for the current channel.
- chan_mask  input  N_RO  channels to scan; sampled on the accepted start.
- ro_out  input  N_RO  raw oscillator outputs; asynchronous to clk.
- ro_en  output  N_RO  oscillator enables, registered; one-hot or zero.
- busy  output  1  high in any state other than IDLE.
- result_valid  output  1  result payload valid.
- result_ready  input  1  consumer accepts the result.
- result_id  output  4  channel index of the result.
- result_count  output  CNT_W  rising edges counted in the window, saturating.
- done  output  1  one-cycle pulse when a scan completes normally.

Behaviour:
- Reset (async, rst_n=0) drives all outputs to 0, the state to IDLE, and all counters and mask registers to 0. This applies mid-operation: ro_en drops immediately and any pending result is lost.
- Input path:
  - ro_out[ch_sel] passes through a mux, then a 2-flop synchroniser, then an edge-detect register.
  - A count event is sync_q=1 and prev_q=0.
  - Counting is valid only for f_ro < f_clk/2. Faster oscillators alias, by design; an external divider is required.
- FSM states: IDLE, SELECT, SETTLE, MEASURE, REPORT, DONE.
- IDLE:
  - start=1 latches chan_mask and goes to SELECT; busy rises the next cycle.
  - start while busy is ignored.
- SELECT:
  - Picks the lowest-index set bit of the remaining mask, sets ch_sel and clears that bit, then goes to SETTLE.
  - If no bit remains, goes to DONE (a mask of all zeros gives done 2 cycles after start, with no results).
- SETTLE:
  - ro_en[ch_sel]=1 from the first SETTLE cycle onward.
  - Lasts exactly SETTLE_CYC cycles. The edge counter clears to 0 and edges are ignored.
- MEASURE:
  - Lasts exactly WINDOW_CYC cycles with ro_en held. Each count event increments the counter.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
- REPORT:
  - On entry, ro_en goes to 0. result_valid=1, result_id=ch_sel, result_count=final count.
  - The payload stays stable while result_valid=1 and result_ready=0 (unlimited backpressure).
  - When result_valid and result_ready are both 1 in a cycle, result_valid drops the next cycle and the state goes to SELECT.
- DONE: done=1 for one cycle, then IDLE; busy falls with the IDLE entry.
- Abort in any non-IDLE state:
  - On the next edge, ro_en goes to 0, result_valid goes to 0 (even if un-handshaken), the remaining mask clears, and the state goes to IDLE.
  - done is not pulsed.
  - abort and start together in IDLE: abort wins and start is dropped.
- Invariants:
  - popcount(ro_en) <= 1 at all times.
  - ro_en is never high outside SETTLE and MEASURE.
- Latency per channel: 1 (SELECT) + SETTLE_CYC + WINDOW_CYC + REPORT cycles, where REPORT is at least 1 cycle.

Test Plan:
- Reset, mask 4'b0001, bench ring model ro_out[0] toggling every 4 clk (period 8), defaults.
  - One result: id=0, count=128 ±1.
  - ro_en[0] high for exactly 16+1024 cycles.
  - done pulses once and busy falls.
- mask 4'b0101 with ring periods 8 and 16, result_ready tied high.
  - Results in order: id=0 count≈128, then id=2 count≈64.
  - ro_en[1] and ro_en[3] never assert.
  - Never more than one ro_en bit high.
- Backpressure: result_ready=0 for 50 cycles during REPORT.
  - result_valid, id and count stay stable and ro_en stays 0.
  - Accepted on the first cycle result_ready=1; next channel enters SELECT the following cycle.
- Saturation: CNT_W=6, WINDOW_CYC=1024, period-4 ring gives 256 edges -> result_count=63.
- Abort at MEASURE cycle 300.
  - ro_en goes to 0 the next cycle, no result_valid, no done, busy goes to 0.
  - A new start then gives a full, correct scan.
- rst_n pulsed low asynchronously (between clk edges) during SETTLE.
  - All outputs go to 0 immediately.
  - start while busy, and start with mask 0: ignored and done-only respectively.

Source files
------------

// File: rtl/ro_scan_controller.sv
// ro_scan_controller
//
// Scans a bank of ring oscillators one at a time. Each selected oscillator is
// enabled, left to settle, then its rising edges are counted over a fixed
// window of clk. The count is offered on a valid/ready result port, and the
// scan moves on to the next channel in the mask.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   start          begin a scan (taken only when idle)
//   abort          stop the scan at once, discarding the current channel
//   chan_mask      channels to scan, captured with start
//   ro_out         raw oscillator outputs (asynchronous to clk)
//   ro_en          oscillator enables, one-hot or zero
//   busy           high whenever a scan is in progress
//   result_valid   result payload valid
//   result_ready   consumer accepts the result
//   result_id      channel index of the result
//   result_count   saturating rising-edge count for the window
//   done           one-cycle pulse at normal scan completion
module ro_scan_controller #(
    parameter int N_RO       = 4,
    parameter int WINDOW_CYC = 1024,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_RO-1:0]   chan_mask,
    input  logic [N_RO-1:0]   ro_out,
    output logic [N_RO-1:0]   ro_en,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [3:0]        result_id,
    output logic [CNT_W-1:0]  result_count,
    output logic              done
);

    localparam int TMR_MAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_MEASURE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_RO-1:0]   mask_q, mask_d;
    logic [N_RO-1:0]   ro_en_q, ro_en_d;
    logic [3:0]        ch_sel_q, ch_sel_d;
    logic [3:0]        low_idx;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              meta_q, meta_d;
    logic              sync_q;
    logic              prev_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Lowest set bit of the remaining mask; scanning downward leaves the
    // lowest index as the last assignment.
    always_comb begin
        low_idx = '0;
        for (int i = N_RO - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // Only the selected oscillator reaches the synchroniser.
    always_comb begin
        meta_d = 1'b0;
        for (int i = 0; i < N_RO; i++) begin
            if (ch_sel_q == 4'(i)) begin
                meta_d = ro_out[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ch_sel_d = ch_sel_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mask_d  = chan_mask;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (mask_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    ch_sel_d = low_idx;
                    // Clears the lowest set bit.
                    mask_d   = mask_q & (mask_q - N_RO'(1));
                    tmr_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = '0;
                if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = S_MEASURE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_MEASURE: begin
                if (sync_q && !prev_q) begin
                    cnt_d = sat_inc(cnt_q);
                end
                if (tmr_q == TMR_W'(WINDOW_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = S_REPORT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_REPORT: begin
                if (result_ready) begin
                    state_d = S_SELECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition except staying idle.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            mask_d  = '0;
        end
    end

    // Enable is registered from the next state so it rises on the first
    // SETTLE cycle and drops on the first cycle after MEASURE.
    always_comb begin
        ro_en_d = '0;
        if (state_d == S_SETTLE || state_d == S_MEASURE) begin
            for (int i = 0; i < N_RO; i++) begin
                ro_en_d[i] = (ch_sel_d == 4'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            ro_en_q  <= '0;
            ch_sel_q <= '0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ro_en_q  <= ro_en_d;
            ch_sel_q <= ch_sel_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            meta_q   <= meta_d;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
        end
    end

    assign ro_en        = ro_en_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign result_valid = (state_q == S_REPORT);
    assign result_id    = ch_sel_q;
    // The counter only moves in SETTLE/MEASURE, so it is stable in REPORT.
    assign result_count = cnt_q;

endmodule

// File: tb/tb_ro_scan_controller.sv
`timescale 1ns/1ps
module tb_ro_scan_controller;

    localparam int N_RO   = 4;
    localparam int WINDOW = 1024;
    localparam int SETTLE = 16;
    localparam int CNT_W  = 16;
    localparam int CLK_NS = 10;

    logic        clk;
    logic        rst_n;
    logic        start, abort, result_ready;
    logic [3:0]  chan_mask, ro_out, ro_en, result_id;
    logic        busy, result_valid, done;
    logic [15:0] result_count;

    logic        s_start, s_abort, s_ready;
    logic [3:0]  s_mask, s_ro_out, s_ro_en, s_id;
    logic        s_busy, s_valid, s_done;
    logic [5:0]  s_count;

    int checks = 0;
    int errors = 0;

    ro_scan_controller #(.N_RO(4), .WINDOW_CYC(WINDOW), .SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chan_mask(chan_mask),
        .ro_out(ro_out), .ro_en(ro_en), .busy(busy), .result_valid(result_valid),
        .result_ready(result_ready), .result_id(result_id), .result_count(result_count),
        .done(done));

    ro_scan_controller #(.N_RO(4), .WINDOW_CYC(WINDOW), .SETTLE_CYC(SETTLE), .CNT_W(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .chan_mask(s_mask),
        .ro_out(s_ro_out), .ro_en(s_ro_en), .busy(s_busy), .result_valid(s_valid),
        .result_ready(s_ready), .result_id(s_id), .result_count(s_count),
        .done(s_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring oscillator models: half period in ns, running only while enabled.
    // Stepping at x.3 ns keeps every toggle off the clock edges.
    int half[4] = '{0, 0, 0, 0};
    int ph[4]   = '{0, 0, 0, 0};
    int s_half  = 0;
    int s_ph    = 0;
    initial begin
        ro_out   = '0;
        s_ro_out = '0;
        #0.3;
        forever begin
            #1;
            for (int i = 0; i < 4; i++) begin
                if (ro_en[i] && half[i] > 0) begin
                    ph[i]++;
                    if (ph[i] >= half[i]) begin
                        ph[i] = 0;
                        ro_out[i] = ~ro_out[i];
                    end
                end else begin
                    ph[i] = 0;
                    ro_out[i] = 1'b0;
                end
            end
            if (s_ro_en[0] && s_half > 0) begin
                s_ph++;
                if (s_ph >= s_half) begin
                    s_ph = 0;
                    s_ro_out[0] = ~s_ro_out[0];
                end
            end else begin
                s_ph = 0;
                s_ro_out[0] = 1'b0;
            end
        end
    end

    // Observation of the main instance, sampled on the falling edge.
    int multi_en, en_bad, done_cnt;
    int en_cycles[4];
    int res_id_q[$];
    int res_cnt_q[$];
    always @(negedge clk) begin
        if ($countones(ro_en) > 1) multi_en++;
        if (ro_en != 4'b0 && (!busy || result_valid || done)) en_bad++;
        for (int i = 0; i < 4; i++) if (ro_en[i]) en_cycles[i]++;
        if (done) done_cnt++;
        if (result_valid && result_ready) begin
            res_id_q.push_back(int'(result_id));
            res_cnt_q.push_back(int'(result_count));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference: rising edges in the window = window time / ring period,
    // clipped to the counter range. Tolerance of one edge for phase.
    function automatic int exp_edges(input int h, input int w);
        int ideal;
        int sat;
        ideal = (WINDOW * CLK_NS) / (2 * h);
        sat   = (1 << w) - 1;
        return (ideal > sat) ? sat : ideal;
    endfunction

    function automatic int exp_tol(input int h, input int w);
        return (((WINDOW * CLK_NS) / (2 * h)) - 1 > ((1 << w) - 1)) ? 0 : 1;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
        checks++;
        assert (obs >= exp - tol && obs <= exp + tol) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        multi_en = 0;
        en_bad   = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) en_cycles[i] = 0;
        res_id_q.delete();
        res_cnt_q.delete();
    endtask

    task automatic do_start(input logic [3:0] m);
        chan_mask = m;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            tick(1);
            t++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_scan(input string tag, input logic [3:0] m);
        int exp_ids[$];
        for (int i = 0; i < 4; i++) if (m[i]) exp_ids.push_back(i);
        chk({tag, "_nres"}, res_id_q.size(), exp_ids.size());
        for (int k = 0; k < exp_ids.size() && k < res_id_q.size(); k++) begin
            chk($sformatf("%s_id%0d", tag, k), res_id_q[k], exp_ids[k]);
            chk_near($sformatf("%s_cnt%0d", tag, k), res_cnt_q[k],
                     exp_edges(half[exp_ids[k]], CNT_W), exp_tol(half[exp_ids[k]], CNT_W));
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_en_cyc%0d", tag, i), en_cycles[i], m[i] ? SETTLE + WINDOW : 0);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_onehot"}, multi_en, 0);
        chk({tag, "_en_outside"}, en_bad, 0);
    endtask

    initial begin
        int t, bad;
        logic [3:0] m;
        int id0, c0;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b1; chan_mask = '0;
        s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1; s_mask = '0;
        clear_stats();
        tick(3);
        chk("rst_ro_en", ro_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_count", result_count, 0);
        chk("rst_id", result_id, 0);
        rst_n = 1'b1;
        tick(2);

        // Single channel, period-8 ring.
        half[0] = 40;
        clear_stats();
        do_start(4'b0001);
        chk("t1_busy_rise", busy, 1);
        wait_idle("t1", 3000);
        check_scan("t1", 4'b0001);

        // Two channels, periods 8 and 16.
        half[2] = 80;
        clear_stats();
        do_start(4'b0101);
        wait_idle("t2", 4000);
        check_scan("t2", 4'b0101);

        // Randomised masks, ring periods and consumer backpressure.
        for (int r = 0; r < 2; r++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) half[i] = $urandom_range(20, 90);
            clear_stats();
            do_start(m);
            t = 0;
            while (busy && t < 8000) begin
                result_ready = 1'($urandom_range(0, 1));
                tick(1);
                t++;
            end
            result_ready = 1'b1;
            chk($sformatf("rnd%0d_idle", r), busy, 0);
            check_scan($sformatf("rnd%0d", r), m);
        end

        // Backpressure held for 50 cycles in REPORT.
        half[0] = 40; half[1] = 40;
        clear_stats();
        result_ready = 1'b0;
        do_start(4'b0011);
        t = 0;
        while (!result_valid && t < 3000) begin
            tick(1);
            t++;
        end
        chk("bp_valid_seen", result_valid, 1);
        id0 = int'(result_id);
        c0  = int'(result_count);
        bad = 0;
        repeat (50) begin
            tick(1);
            if (result_valid !== 1'b1 || int'(result_id) != id0 ||
                int'(result_count) != c0 || ro_en !== 4'b0) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_id", id0, 0);
        chk_near("bp_count", c0, exp_edges(40, CNT_W), 1);
        result_ready = 1'b1;
        tick(1);
        chk("bp_valid_drop", result_valid, 0);
        chk("bp_en_in_select", ro_en, 0);
        tick(1);
        chk("bp_next_settle", ro_en, 4'b0010);
        wait_idle("bp", 3000);
        check_scan("bp", 4'b0011);

        // Abort at MEASURE cycle 300.
        clear_stats();
        do_start(4'b0001);
        t = 0;
        while (!ro_en[0] && t < 10) begin
            tick(1);
            t++;
        end
        chk("ab_en_rise", ro_en, 4'b0001);
        tick(SETTLE + 300);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("ab_ro_en", ro_en, 0);
        chk("ab_busy", busy, 0);
        chk("ab_valid", result_valid, 0);
        tick(5);
        chk("ab_no_done", done_cnt, 0);
        chk("ab_no_result", res_id_q.size(), 0);
        clear_stats();
        do_start(4'b0001);
        wait_idle("ab_rescan", 3000);
        check_scan("ab_rescan", 4'b0001);

        // abort and start together while idle: nothing starts.
        abort = 1'b1;
        do_start(4'b0001);
        abort = 1'b0;
        chk("ab_start_idle", busy, 0);

        // Asynchronous reset in the middle of SETTLE.
        clear_stats();
        do_start(4'b0010);
        tick(4);
        chk("rs_en_before", ro_en, 4'b0010);
        #3 rst_n = 1'b0;
        #1;
        chk("rs_ro_en", ro_en, 0);
        chk("rs_busy", busy, 0);
        chk("rs_valid", result_valid, 0);
        chk("rs_done", done, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("rs_still_idle", busy, 0);

        // start while busy is ignored.
        clear_stats();
        do_start(4'b0001);
        tick(3);
        do_start(4'b1111);
        wait_idle("sb", 3000);
        check_scan("sb", 4'b0001);

        // Empty mask: done only, two cycles after start.
        clear_stats();
        do_start(4'b0000);
        chk("m0_busy", busy, 1);
        chk("m0_done_early", done, 0);
        tick(1);
        chk("m0_done", done, 1);
        tick(1);
        chk("m0_done_fall", done, 0);
        chk("m0_busy_fall", busy, 0);
        chk("m0_nres", res_id_q.size(), 0);
        chk("m0_done_cnt", done_cnt, 1);

        // Saturation on the 6-bit instance with a period-4 ring.
        s_half = 20;
        s_mask = 4'b0001;
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        t = 0;
        while (!s_valid && t < 3000) begin
            tick(1);
            t++;
        end
        chk("sat_valid", s_valid, 1);
        chk("sat_id", s_id, 0);
        chk_near("sat_count", s_count, exp_edges(s_half, 6), exp_tol(s_half, 6));
        tick(3);
        chk("sat_idle", s_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
